joy_db15_responder: RTL

//  Target end of the serial DB15 SNAC joystick link: emulates the 74HC165 shift-register chain

---
 rtl/joy_db15_pkg.sv | 19 +
 rtl/joy_db15_responder_sync_filter.sv | 48 ++++
 rtl/joy_db15_responder.sv | 108 ++++++++++
 3 files changed

// File: rtl/joy_db15_pkg.sv
// Shared definitions for the DB15 SNAC joystick link (responder and reader-side models).
package joy_db15_pkg;

  localparam int unsigned PAD_BITS_DEFAULT   = 16;
  localparam int unsigned FRAME_BITS_DEFAULT = 2 * PAD_BITS_DEFAULT;

  typedef enum logic [1:0] {
    IDLE,
    LOADED,
    SHIFT,
    DONE
  } state_t;

  // Bit index has to be able to hold the full frame length, not just the last index.
  function automatic int unsigned idx_width(input int unsigned frame_bits);
    return $clog2(frame_bits + 1);
  endfunction

endpackage

// File: rtl/joy_db15_responder_sync_filter.sv
// Asynchronous pin synchronizer followed by a level filter and registered edge pulses.
module sync_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // A new level is accepted only after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      cnt_q  <= '0;
      level  <= 1'b1;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (synced == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level <= synced;
        rise  <= synced;
        fall  <= ~synced;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/joy_db15_responder.sv
// Emulates the 74HC165 chain of a DB15 adapter: parallel pad words in, active-low serial out.
module joy_db15_responder
  import joy_db15_pkg::*;
#(
  parameter int unsigned PAD_BITS    = PAD_BITS_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 2,
  parameter int unsigned TIMEOUT_CYC = 48000,
  localparam int unsigned FRAME_BITS = 2 * PAD_BITS,
  localparam int unsigned IDX_W      = idx_width(FRAME_BITS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PAD_BITS-1:0] joystick1,
  input  logic [PAD_BITS-1:0] joystick2,
  input  logic                JOY_CLK,
  input  logic                JOY_LOAD,
  output logic                JOY_DATA,
  output logic                host_active,
  output logic                frame_done,
  output logic [IDX_W-1:0]    bit_idx
);

  localparam int unsigned       WD_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(FRAME_BITS - 1);

  state_t                state_q, state_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [IDX_W-1:0]      idx_d;
  logic                  done_d;
  logic [WD_W-1:0]       wd_q;
  logic                  seen_q;

  logic clk_lvl, clk_rise, clk_fall;
  logic load_lvl, load_rise, load_fall;
  logic unused_clk;

  sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_clk_filt (
    .clk(clk), .reset(reset), .din(JOY_CLK),
    .level(clk_lvl), .rise(clk_rise), .fall(clk_fall)
  );

  sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_load_filt (
    .clk(clk), .reset(reset), .din(JOY_LOAD),
    .level(load_lvl), .rise(load_rise), .fall(load_fall)
  );

  assign unused_clk  = clk_lvl ^ clk_fall;
  assign host_active = seen_q && (wd_q != WD_MAX);

  // Load level is checked first so it dominates both shifting and timeout.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = bit_idx;
    done_d  = 1'b0;
    if (!load_lvl) begin
      state_d = LOADED;
      sr_d    = ~{joystick1, joystick2};
      idx_d   = '0;
    end else if ((wd_q == WD_MAX) && (state_q != IDLE)) begin
      state_d = IDLE;
      sr_d    = '1;
    end else begin
      case (state_q)
        LOADED: if (load_rise) state_d = SHIFT;
        SHIFT: begin
          if (clk_rise) begin
            sr_d  = {sr_q[FRAME_BITS-2:0], 1'b1};
            idx_d = bit_idx + 1'b1;
            if (bit_idx == IDX_LAST) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        DONE: if (clk_rise) sr_d = {sr_q[FRAME_BITS-2:0], 1'b1};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sr_q       <= '1;
      bit_idx    <= '0;
      frame_done <= 1'b0;
      JOY_DATA   <= 1'b1;
      wd_q       <= '0;
      seen_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_idx    <= idx_d;
      frame_done <= done_d;
      JOY_DATA   <= sr_q[FRAME_BITS-1];
      if (load_fall) begin
        wd_q   <= '0;
        seen_q <= 1'b1;
      end else if (wd_q != WD_MAX) begin
        wd_q <= wd_q + 1'b1;
      end
    end
  end

endmodule
